block_ram_stream_writer: RTL and testbench
==========================================

Name: block_ram_stream_writer

Overview:
- Write-side companion to the team's read-only synchronous block RAM.
- Accepts a valid/ready data stream and writes a programmed number of words into consecutive RAM addresses, starting at a programmed base and wrapping modulo memDepth.
- Drives the write port (enable/address/data) of the shared RAM so that the read-side RAM later sees filled contents.
- Sits between a producer (DMA, pixel or feature-map stream) and the RAM.

Parameters:
- blockLength, 32, word width in bits.
- memDepth, 1024, RAM depth in words; must equal 2**addressBitWidth.
- addressBitWidth, 10, RAM address width.

Ports:
- clock  input  1  sole clock; all logic on rising edge.
- resetN  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a fill; honoured only in IDLE.
- abort  input  1  terminates an in-progress fill.
- baseAddress  input  addressBitWidth  first write address, sampled on accepted start.
- length  input  addressBitWidth+1  word count, 0..memDepth, sampled on accepted start.
- dataIn  input  blockLength  stream data.
- dataInValid  input  1  producer has a word.
- dataInReady  output  1  writer accepts a word this cycle.
- writeEnable  output  1  RAM write strobe.
- writeAddress  output  addressBitWidth  RAM write address.
- writeData  output  blockLength  RAM write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (resetN=0 at a clock edge):
  - State becomes IDLE.
  - writeEnable, writeAddress, writeData, done and the internal counters are cleared to 0.
  - busy and dataInReady go to 0 as a consequence of IDLE.
  - Reset mid-fill abandons the fill immediately; no further writes occur and done is not pulsed.
- States: IDLE, FILL, DONE.
- IDLE:
  - dataInReady=0.
  - start=1 and length!=0: latch base and length, go to FILL.
  - start=1 and length=0: go to DONE; no writes occur.
- FILL:
  - dataInReady = !abort (derived combinationally from state and abort).
  - A beat is accepted when dataInValid & dataInReady.
  - Each accepted beat, at the next edge: writeEnable=1, writeAddress=current address, writeData=dataIn. The write appears on the port 1 cycle after acceptance.
  - After each accepted beat, the address increments modulo memDepth (wrap from memDepth-1 to 0) and the remaining count decrements.
  - Acceptance of the final beat (remaining=1): go to DONE.
  - abort=1: go to IDLE; no beat is accepted that cycle; a write already registered from the previous cycle still completes; done is not pulsed.
  - dataInValid low: no write occurs and no state change; stalls of any length are allowed.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE.
  - For length!=0, done coincides with the final writeEnable pulse.
- writeEnable is a registered one-cycle strobe per accepted beat. Back-to-back beats produce one write per cycle.
- start outside IDLE is ignored (including in DONE).
- length=memDepth writes every location exactly once.
- Throughput: 1 word/cycle. Latency: start to first possible acceptance is 1 cycle.

Optional Feature:
- Macro: BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[blockLength-1:0], a running XOR of all words written in the current fill.
  - Cleared on reset and on an accepted start.
  - Final value is valid from the done cycle until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - State encoding constants IDLE/FILL/DONE.
  - Default values of blockLength/memDepth/addressBitWidth, shared with the RAM block.
- One natural sub-module, ram_write_addr_gen:
  - Contains the loadable wrapping address counter and the remaining-count down-counter.
  - Inputs: load, step. Outputs: address, last.
- The FSM and the registered write port stay in the top module.

Test Plan:
- Basic fill: reset, base=5, length=4, continuous valid, data 0xA0..0xA3 -> writes to addresses 5,6,7,8 on 4 consecutive cycles with data 0xA0..0xA3; done is high with the 4th write; busy is 0 the next cycle.
- Wrap: base=1022, length=4 -> writes to addresses 1022,1023,0,1 in order; done pulses once.
- Stalls: length=3, valid toggled 1,0,0,1,0,1 -> exactly 3 writes with no gaps filled by spurious strobes; addresses contiguous; done is high with the last write.
- Zero length and ignored start: start with length=0 -> done pulses 1 cycle after start, writeEnable never asserts. A second start during FILL -> ignored; the write count equals the original length.
- Abort and reset: length=8, abort after 3 accepted beats -> exactly 3 writes, no done, IDLE next cycle. Repeat with resetN=0 after 2 beats -> at most the already-registered write appears, then all outputs are 0.
- Checksum (macro defined): write 0x1, 0x2, 0x4 -> checksum=0x7 at done. A new start clears it to 0.

Source files
------------

// File: rtl/block_ram_stream_writer_pkg.sv
// Shared definitions for the block RAM stream writer and its companion RAM.
package block_ram_stream_writer_pkg;

   localparam int unsigned BLOCK_LENGTH_DEF = 32;
   localparam int unsigned ADDR_BITS_DEF    = 10;
   localparam int unsigned MEM_DEPTH_DEF    = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } wr_state_t;

endpackage

// File: rtl/block_ram_stream_writer_ram_write_addr_gen.sv
// Loadable wrapping write-address counter plus remaining-word down-counter.
module ram_write_addr_gen
   import block_ram_stream_writer_pkg::*;
#(
   parameter int unsigned addressBitWidth = ADDR_BITS_DEF,
   parameter int unsigned memDepth        = MEM_DEPTH_DEF
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic                       load_i,
   input  logic                       step_i,
   input  logic [addressBitWidth-1:0] base_i,
   input  logic [addressBitWidth:0]   length_i,
   output logic [addressBitWidth-1:0] address_o,
   output logic                       last_c
);

   localparam int unsigned AW = addressBitWidth;

   logic [AW-1:0] address_q, address_d;
   logic [AW:0]   remaining_q, remaining_d;

   // Next address/count: load wins over step; address wraps at memDepth-1.
   always_comb begin
      address_d   = address_q;
      remaining_d = remaining_q;
      if (load_i) begin
         address_d   = base_i;
         remaining_d = length_i;
      end else if (step_i) begin
         address_d   = (address_q == AW'(memDepth - 1)) ? '0 : address_q + AW'(1);
         remaining_d = remaining_q - (AW+1)'(1);
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         address_q   <= '0;
         remaining_q <= '0;
      end else begin
         address_q   <= address_d;
         remaining_q <= remaining_d;
      end
   end

   assign address_o = address_q;
   assign last_c    = (remaining_q == (AW+1)'(1));

endmodule

// File: rtl/block_ram_stream_writer.sv
// Stream-to-RAM fill engine: writes a programmed number of valid/ready beats
// into consecutive (wrapping) RAM addresses starting at a programmed base.
// Optional macro BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN adds a running XOR checksum output.
module block_ram_stream_writer
   import block_ram_stream_writer_pkg::*;
#(
   parameter int unsigned blockLength     = BLOCK_LENGTH_DEF,
   parameter int unsigned memDepth        = MEM_DEPTH_DEF,
   parameter int unsigned addressBitWidth = ADDR_BITS_DEF
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic                       start,
   input  logic                       abort,
   input  logic [addressBitWidth-1:0] baseAddress,
   input  logic [addressBitWidth:0]   length,
   input  logic [blockLength-1:0]     dataIn,
   input  logic                       dataInValid,
   output logic                       dataInReady,
   output logic                       writeEnable,
   output logic [addressBitWidth-1:0] writeAddress,
   output logic [blockLength-1:0]     writeData,
   output logic                       busy,
   output logic                       done
`ifdef BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN
   ,
   output logic [blockLength-1:0]     checksum
`endif
);

   wr_state_t                  state_q;
   logic                       we_q;
   logic [addressBitWidth-1:0] addr_q;
   logic [blockLength-1:0]     data_q;
   logic                       done_q;

   logic                       accept_c;
   logic                       start_ok_c;
   logic                       load_c;
   logic [addressBitWidth-1:0] gen_addr;
   logic                       gen_last_c;

   assign dataInReady = (state_q == ST_FILL) && !abort;
   assign accept_c    = dataInReady && dataInValid;
   assign start_ok_c  = (state_q == ST_IDLE) && start;
   assign load_c      = start_ok_c && (length != '0);

   ram_write_addr_gen #(
      .addressBitWidth (addressBitWidth),
      .memDepth        (memDepth)
   ) u_addr_gen (
      .clock     (clock),
      .resetN    (resetN),
      .load_i    (load_c),
      .step_i    (accept_c),
      .base_i    (baseAddress),
      .length_i  (length),
      .address_o (gen_addr),
      .last_c    (gen_last_c)
   );

   // Control FSM and registered RAM write port.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FILL;
                  end
               end
            end
            ST_FILL: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else if (accept_c) begin
                  we_q   <= 1'b1;
                  addr_q <= gen_addr;
                  data_q <= dataIn;
                  if (gen_last_c) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN
   logic [blockLength-1:0] checksum_q;

   // Running XOR of accepted words; restarts on every accepted start.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         checksum_q <= '0;
      end else if (start_ok_c) begin
         checksum_q <= '0;
      end else if (accept_c) begin
         checksum_q <= checksum_q ^ dataIn;
      end
   end

   assign checksum = checksum_q;
`endif

   assign writeEnable  = we_q;
   assign writeAddress = addr_q;
   assign writeData    = data_q;
   assign done         = done_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_block_ram_stream_writer.sv
// Directed bench for block_ram_stream_writer with a transaction-level fill model.
module tb_block_ram_stream_writer;

   localparam int unsigned BL    = 32;
   localparam int unsigned AW    = 10;
   localparam int          DEPTH = 1024;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] baseAddress = '0;
   logic [AW:0]   length = '0;
   logic [BL-1:0] dataIn = '0;
   logic          dataInValid = 1'b0;
   logic          dataInReady;
   logic          writeEnable;
   logic [AW-1:0] writeAddress;
   logic [BL-1:0] writeData;
   logic          busy;
   logic          done;
`ifdef BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN
   logic [BL-1:0] checksum;
`endif

   always #5 clock = ~clock;

   block_ram_stream_writer dut (
      .clock        (clock),
      .resetN       (resetN),
      .start        (start),
      .abort        (abort),
      .baseAddress  (baseAddress),
      .length       (length),
      .dataIn       (dataIn),
      .dataInValid  (dataInValid),
      .dataInReady  (dataInReady),
      .writeEnable  (writeEnable),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .busy         (busy),
      .done         (done)
`ifdef BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Fill model: a fill is "active" with a next address and a words-left count.
   bit            m_active = 1'b0;
   int            m_addr = 0;
   int            m_left = 0;
   bit            e_we = 1'b0;
   bit            e_done = 1'b0;
   bit            prev_done = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [BL-1:0] e_data = '0;
   logic [BL-1:0] e_chk = '0;

   // Observed DUT write log.
   int            wr_addr[$];
   logic [BL-1:0] wr_data[$];
   bit            wr_done[$];
   int            done_cnt = 0;
   logic [BL-1:0] done_chk = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: update model from inputs at the edge, compare at the falling edge.
   task automatic tick();
      @(posedge clock);
      prev_done = e_done;
      e_we      = 1'b0;
      e_done    = 1'b0;
      if (!resetN) begin
         m_active = 1'b0;
         m_addr   = 0;
         m_left   = 0;
         e_addr   = '0;
         e_data   = '0;
         e_chk    = '0;
      end else if (m_active) begin
         if (abort) begin
            m_active = 1'b0;
         end else if (dataInValid) begin
            e_we   = 1'b1;
            e_addr = AW'(m_addr);
            e_data = dataIn;
            e_chk  = e_chk ^ dataIn;
            m_addr = (m_addr + 1) % DEPTH;
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_active = 1'b0;
               e_done   = 1'b1;
            end
         end
      end else if (!prev_done && start) begin
         e_chk = '0;
         if (length == '0) begin
            e_done = 1'b1;
         end else begin
            m_active = 1'b1;
            m_addr   = int'(baseAddress);
            m_left   = int'(length);
         end
      end
      @(negedge clock);
      chk("writeEnable", 64'(writeEnable), 64'(e_we));
      chk("done", 64'(done), 64'(e_done));
      chk("busy", 64'(busy), 64'(m_active || e_done));
      chk("dataInReady", 64'(dataInReady), 64'(m_active && !abort));
      if (e_we) begin
         chk("writeAddress", 64'(writeAddress), 64'(e_addr));
         chk("writeData", 64'(writeData), 64'(e_data));
      end
`ifdef BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(e_chk));
      if (done) done_chk = checksum;
`endif
      if (writeEnable) begin
         wr_addr.push_back(int'(writeAddress));
         wr_data.push_back(writeData);
         wr_done.push_back(done);
      end
      if (done) done_cnt++;
   endtask

   task automatic start_fill(input int base, input int len);
      baseAddress = AW'(base);
      length      = (AW+1)'(len);
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   int s;
   int d0;
   bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   int wrap_exp[4] = '{1022, 1023, 0, 1};

   initial begin
      // Reset
      tick();
      tick();
      chk("reset_we", 64'(writeEnable), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_addr", 64'(writeAddress), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      resetN = 1'b1;
      tick();

      // Basic fill: base 5, four words
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(5, 4);
      dataInValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dataIn = BL'(32'hA0 + i);
         tick();
      end
      dataInValid = 1'b0;
      tick();
      chk("basic_busy_after", 64'(busy), 64'd0);
      tick();
      chk("basic_count", 64'(wr_addr.size() - s), 64'd4);
      if (wr_addr.size() - s == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("basic_addr", 64'(wr_addr[s+i]), 64'(5 + i));
            chk("basic_data", 64'(wr_data[s+i]), 64'(32'hA0 + i));
         end
         chk("basic_done_with_last", 64'(wr_done[s+3]), 64'd1);
      end
      chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Wrap at top of memory
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(1022, 4);
      dataInValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dataIn = BL'(32'hB0 + i);
         tick();
      end
      dataInValid = 1'b0;
      tick();
      tick();
      chk("wrap_count", 64'(wr_addr.size() - s), 64'd4);
      if (wr_addr.size() - s == 4) begin
         for (int i = 0; i < 4; i++) chk("wrap_addr", 64'(wr_addr[s+i]), 64'(wrap_exp[i]));
      end
      chk("wrap_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Stalled producer
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(100, 3);
      for (int k = 0; k < 6; k++) begin
         dataInValid = pat[k];
         dataIn      = BL'(32'hC0 + k);
         tick();
      end
      dataInValid = 1'b0;
      tick();
      tick();
      chk("stall_count", 64'(wr_addr.size() - s), 64'd3);
      if (wr_addr.size() - s == 3) begin
         chk("stall_addr0", 64'(wr_addr[s]), 64'd100);
         chk("stall_addr2", 64'(wr_addr[s+2]), 64'd102);
         chk("stall_data1", 64'(wr_data[s+1]), 64'h0C3);
         chk("stall_data2", 64'(wr_data[s+2]), 64'h0C5);
         chk("stall_done_with_last", 64'(wr_done[s+2]), 64'd1);
      end
      chk("stall_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Zero length, then a start during the done cycle is ignored
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(7, 0);
      chk("zero_done_next_cycle", 64'(done), 64'd1);
      baseAddress = AW'(9);
      length      = (AW+1)'(4);
      start       = 1'b1;
      dataInValid = 1'b1;
      tick();
      start       = 1'b0;
      tick();
      tick();
      dataInValid = 1'b0;
      chk("zero_no_writes", 64'(wr_addr.size() - s), 64'd0);
      chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Start during fill is ignored
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(200, 5);
      dataInValid = 1'b1;
      baseAddress = AW'(300);
      length      = (AW+1)'(2);
      for (int i = 0; i < 5; i++) begin
         dataIn = BL'(32'hD0 + i);
         start  = (i == 2);
         tick();
      end
      start       = 1'b0;
      dataInValid = 1'b0;
      tick();
      tick();
      chk("restart_count", 64'(wr_addr.size() - s), 64'd5);
      if (wr_addr.size() - s == 5) begin
         chk("restart_addr0", 64'(wr_addr[s]), 64'd200);
         chk("restart_addr4", 64'(wr_addr[s+4]), 64'd204);
      end
      chk("restart_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Abort after three beats
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(50, 8);
      dataInValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dataIn = BL'(32'hE0 + i);
         tick();
      end
      abort = 1'b1;
      tick();
      chk("abort_idle", 64'(busy), 64'd0);
      abort       = 1'b0;
      dataInValid = 1'b0;
      tick();
      tick();
      chk("abort_count", 64'(wr_addr.size() - s), 64'd3);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

      // Reset mid-fill after two beats
      s = wr_addr.size(); d0 = done_cnt;
      start_fill(60, 8);
      dataInValid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dataIn = BL'(32'hF0 + i);
         tick();
      end
      resetN = 1'b0;
      tick();
      chk("rst_we", 64'(writeEnable), 64'd0);
      chk("rst_addr", 64'(writeAddress), 64'd0);
      chk("rst_data", 64'(writeData), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      resetN      = 1'b1;
      dataInValid = 1'b0;
      tick();
      tick();
      chk("rst_count", 64'(wr_addr.size() - s), 64'd2);
      chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef BLOCK_RAM_STREAM_WRITER_CHECKSUM_EN
      // Checksum over 1,2,4 then cleared by a new start
      start_fill(400, 3);
      dataInValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dataIn = BL'(1 << i);
         tick();
      end
      dataInValid = 1'b0;
      tick();
      chk("checksum_at_done", 64'(done_chk), 64'h7);
      chk("checksum_held", 64'(checksum), 64'h7);
      start_fill(410, 1);
      chk("checksum_cleared", 64'(checksum), 64'h0);
      dataInValid = 1'b1;
      dataIn      = BL'(9);
      tick();
      dataInValid = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
